// File: rtl/branch_rs_age_pkg.sv
// rv32i_types: opcodes and record types for the age-ordered branch reservation station.
// Prediction fields are present only when BRANCH_RS_PREDICT_EN is defined.
package rv32i_types;
  localparam int RS_W = 3;
  localparam int ROB_W = 3;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR = 7'b1100011;
  typedef struct packed {
    logic busy;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [31:0] imm;
    logic [31:0] pc;
    logic rs1_ready;
    logic [31:0] rs1_v;
    logic [ROB_W-1:0] rs1_rob;
    logic rs2_ready;
    logic [31:0] rs2_v;
    logic [ROB_W-1:0] rs2_rob;
    logic [ROB_W-1:0] target_rob;
`ifdef BRANCH_RS_PREDICT_EN
    logic pred_take;
    logic [31:0] pred_pc;
`endif
  } branch_rs_entry_t;
  typedef struct packed {
    logic valid;
    logic take;
    logic [31:0] target_pc;
    logic [31:0] v;
    logic [ROB_W-1:0] rob;
`ifdef BRANCH_RS_PREDICT_EN
    logic mispredict;
`endif
  } branch_result_t;
endpackage

// File: rtl/branch_rs_age_select.sv
// branch_rs_age_select: combinational pick of the ready entry closest to the ROB head.
module branch_rs_age_select #(
  parameter int DEPTH = 3,
  parameter int ROB_DEPTH = 3
) (
  input  logic [2**DEPTH-1:0]                ready,
  input  logic [2**DEPTH-1:0][ROB_DEPTH-1:0] tags,
  input  logic [ROB_DEPTH-1:0]               rob_head,
  output logic [DEPTH-1:0]                   idx,
  output logic                               found
);
  logic [ROB_DEPTH-1:0] best, age;
  always_comb begin
    idx = '0;
    found = 1'b0;
    best = '0;
    age = '0;
    for (int i = 0; i < 2**DEPTH; i++) begin
      age = tags[i] - rob_head;
      if (ready[i] && (!found || age < best)) begin
        idx = DEPTH'(i);
        found = 1'b1;
        best = age;
      end
    end
  end
endmodule

// File: rtl/cmp.sv
// cmp: RV32I branch condition evaluator selected by funct3.
module cmp (
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        br_en
);
  always_comb
    case (funct3)
      3'b000:  br_en = a == b;
      3'b001:  br_en = a != b;
      3'b100:  br_en = $signed(a) < $signed(b);
      3'b101:  br_en = $signed(a) >= $signed(b);
      3'b110:  br_en = a < b;
      3'b111:  br_en = a >= b;
      default: br_en = 1'b0;
    endcase
endmodule

// File: rtl/branch_rs_age.sv
// branch_rs_age: branch/jump reservation station with oldest-first select and a registered execute stage.
// Define BRANCH_RS_PREDICT_EN to carry a per-entry prediction and emit cdb_branch_mispredict.
module branch_rs_age import rv32i_types::*; #(
  parameter int BRANCH_RS_DEPTH = RS_W,
  parameter int ROB_DEPTH = ROB_W,
  parameter int CDB_SIZE = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               move_flush,
  input  logic                               branch_rs_issue,
  output logic                               branch_rs_full,
  output logic [BRANCH_RS_DEPTH:0]           branch_rs_free_cnt,
  input  logic [ROB_DEPTH-1:0]               rob_head,
  input  logic [6:0]                         issue_opcode,
  input  logic [2:0]                         issue_funct3,
  input  logic [31:0]                        issue_imm,
  input  logic [31:0]                        issue_pc,
  input  logic [ROB_DEPTH-1:0]               issue_target_rob,
  input  logic                               issue_rs1_regfile_ready,
  input  logic [31:0]                        issue_rs1_regfile_v,
  input  logic [ROB_DEPTH-1:0]               issue_rs1_regfile_rob,
  input  logic                               issue_rs2_regfile_ready,
  input  logic [31:0]                        issue_rs2_regfile_v,
  input  logic [ROB_DEPTH-1:0]               issue_rs2_regfile_rob,
  input  logic                               issue_rs1_rob_ready,
  input  logic [31:0]                        issue_rs1_rob_v,
  input  logic                               issue_rs2_rob_ready,
  input  logic [31:0]                        issue_rs2_rob_v,
`ifdef BRANCH_RS_PREDICT_EN
  input  logic                               issue_pred_take,
  input  logic [31:0]                        issue_pred_pc,
  output logic                               cdb_branch_mispredict,
`endif
  input  logic [CDB_SIZE-1:0]                cdb_valid,
  input  logic [CDB_SIZE-1:0][ROB_DEPTH-1:0] cdb_rob,
  input  logic [CDB_SIZE-1:0][31:0]          cdb_rd_v,
  input  logic                               cdb_branch_rs_ready,
  output logic                               cdb_branch_rs_valid,
  output logic [31:0]                        cdb_branch_rs_v,
  output logic [ROB_DEPTH-1:0]               cdb_branch_rs_rob,
  output logic                               cdb_branch_take,
  output logic [31:0]                        cdb_branch_target_pc
);
  localparam int N = 2**BRANCH_RS_DEPTH;
  branch_rs_entry_t rs [N];
  branch_rs_entry_t ne, pe;
  branch_result_t ex, res;
  logic [N-1:0] ready;
  logic [N-1:0][ROB_DEPTH-1:0] tags;
  logic [BRANCH_RS_DEPTH-1:0] alloc_idx, pick_idx;
  logic found, pick, br_en, w1, w2;
  always_comb begin
    alloc_idx = '0;
    branch_rs_free_cnt = '0;
    for (int i = N-1; i >= 0; i--) begin
      ready[i] = rs[i].busy && rs[i].rs1_ready && rs[i].rs2_ready;
      tags[i] = rs[i].target_rob;
      if (!rs[i].busy) begin
        alloc_idx = BRANCH_RS_DEPTH'(i);
        branch_rs_free_cnt = branch_rs_free_cnt + (BRANCH_RS_DEPTH+1)'(1);
      end
    end
  end
  assign branch_rs_full = branch_rs_free_cnt == '0;
  // Operand capture order: regfile, ROB, then a same-cycle CDB bypass (highest channel wins).
  always_comb begin
    ne = '0;
    ne.busy = 1'b1;
    ne.opcode = issue_opcode;
    ne.funct3 = issue_funct3;
    ne.imm = issue_imm;
    ne.pc = issue_pc;
    ne.target_rob = issue_target_rob;
    ne.rs1_rob = issue_rs1_regfile_rob;
    ne.rs2_rob = issue_rs2_regfile_rob;
    ne.rs1_ready = issue_opcode == OP_JAL || issue_rs1_regfile_ready || issue_rs1_rob_ready;
    ne.rs2_ready = issue_opcode != OP_BR || issue_rs2_regfile_ready || issue_rs2_rob_ready;
    ne.rs1_v = issue_rs1_regfile_ready ? issue_rs1_regfile_v : issue_rs1_rob_v;
    ne.rs2_v = issue_rs2_regfile_ready ? issue_rs2_regfile_v : issue_rs2_rob_v;
`ifdef BRANCH_RS_PREDICT_EN
    ne.pred_take = issue_pred_take;
    ne.pred_pc = issue_pred_pc;
`endif
    w1 = !ne.rs1_ready;
    w2 = !ne.rs2_ready;
    for (int c = 0; c < CDB_SIZE; c++) begin
      if (w1 && cdb_valid[c] && cdb_rob[c] == issue_rs1_regfile_rob) begin
        ne.rs1_ready = 1'b1;
        ne.rs1_v = cdb_rd_v[c];
      end
      if (w2 && cdb_valid[c] && cdb_rob[c] == issue_rs2_regfile_rob) begin
        ne.rs2_ready = 1'b1;
        ne.rs2_v = cdb_rd_v[c];
      end
    end
  end
  branch_rs_age_select #(.DEPTH(BRANCH_RS_DEPTH), .ROB_DEPTH(ROB_DEPTH)) u_select (
    .ready(ready), .tags(tags), .rob_head(rob_head), .idx(pick_idx), .found(found)
  );
  assign pick = found && (!ex.valid || cdb_branch_rs_ready);
  assign pe = rs[pick_idx];
  cmp u_cmp (.funct3(pe.funct3), .a(pe.rs1_v), .b(pe.rs2_v), .br_en(br_en));
  always_comb begin
    res = '0;
    res.valid = 1'b1;
    res.rob = pe.target_rob;
    res.take = pe.opcode == OP_JAL || pe.opcode == OP_JALR || br_en;
    res.target_pc = pe.opcode == OP_JALR ? (pe.rs1_v + pe.imm) & ~32'h1 :
                    res.take ? pe.pc + pe.imm : pe.pc + 32'd4;
    res.v = pe.opcode == OP_BR ? 32'd0 : pe.pc + 32'd4;
`ifdef BRANCH_RS_PREDICT_EN
    res.mispredict = res.take != pe.pred_take || (res.take && res.target_pc != pe.pred_pc);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst || move_flush) begin
      for (int i = 0; i < N; i++) rs[i] <= '0;
      ex <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (rs[i].busy)
          for (int c = 0; c < CDB_SIZE; c++) begin
            if (cdb_valid[c] && !rs[i].rs1_ready && cdb_rob[c] == rs[i].rs1_rob) begin
              rs[i].rs1_ready <= 1'b1;
              rs[i].rs1_v <= cdb_rd_v[c];
            end
            if (cdb_valid[c] && !rs[i].rs2_ready && cdb_rob[c] == rs[i].rs2_rob) begin
              rs[i].rs2_ready <= 1'b1;
              rs[i].rs2_v <= cdb_rd_v[c];
            end
          end
      if (pick) rs[pick_idx].busy <= 1'b0;
      if (branch_rs_issue && !branch_rs_full) rs[alloc_idx] <= ne;
      if (pick) ex <= res;
      else if (ex.valid && cdb_branch_rs_ready) ex <= '0;
    end
  end
  assign cdb_branch_rs_valid = ex.valid;
  assign cdb_branch_rs_v = ex.v;
  assign cdb_branch_rs_rob = ex.rob;
  assign cdb_branch_take = ex.take;
  assign cdb_branch_target_pc = ex.target_pc;
`ifdef BRANCH_RS_PREDICT_EN
  assign cdb_branch_mispredict = ex.mispredict;
`endif
endmodule
